dppl_oversampled: RTL

Parametrised oversampling digital PLL for the SIE receive path. Recovers bit timing from the synchronised differential line (dp/dn) using a phase counter with ±1-cycle edge correction. Emits a one-cycle sample strobe with the sampled line state, SE0 flag and lock status to the NRZI decoder / bit-unstuffer. Generalises the fixed 4x gray-code DPPL to any power-of-two oversampling ratio, and adds lock tracking, idle timeout and optional glitch filtering.

---
 rtl/dppl_oversampled.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dppl_oversampled.sv
// Oversampling digital PLL for the SIE receive path: recovers bit timing from dp/dn.
// Define DPPL_GLITCH_FILTER_EN to add a 3-sample majority filter on dp/dn.
module dppl_oversampled #(
    parameter int unsigned OVERSAMPLE = 4,
    parameter int unsigned LOCK_EDGES = 2,
    parameter int unsigned IDLE_BITS  = 7
) (
    input  logic clk48,
    input  logic RST_N,
    input  logic dpIn,
    input  logic dnIn,
    output logic bitStrobe,
    output logic bitValue,
    output logic se0,
    output logic locked
);

    localparam int unsigned PW = $clog2(OVERSAMPLE);
    localparam int unsigned EW = $clog2(LOCK_EDGES + 1);
    localparam int unsigned IW = $clog2(IDLE_BITS + 1);
    localparam logic [PW-1:0] SP     = PW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] EC_LCK = EW'(LOCK_EDGES - 1);
    localparam logic [IW-1:0] IC_TO  = IW'(IDLE_BITS - 1);

    typedef enum logic [1:0] {StHunt, StLocking, StLocked} state_e;

    state_e        state_q;
    logic [PW-1:0] phase_q;
    logic [EW-1:0] edge_cnt_q;
    logic [IW-1:0] idle_cnt_q;
    logic          dp_r, dn_r, dp_p;
    logic          dp_s, dn_s;
    logic          edge_det;
    logic          sample_pt;

    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            dp_r <= 1'b0;
            dn_r <= 1'b0;
        end else begin
            dp_r <= dpIn;
            dn_r <= dnIn;
        end
    end

`ifdef DPPL_GLITCH_FILTER_EN
    logic [1:0] dp_h, dn_h;

    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            dp_h <= 2'b00;
            dn_h <= 2'b00;
        end else begin
            dp_h <= {dp_h[0], dp_r};
            dn_h <= {dn_h[0], dn_r};
        end
    end

    // Vote over the registered samples so the filter adds only one cycle of latency.
    assign dp_s = (dp_r & dp_h[0]) | (dp_r & dp_h[1]) | (dp_h[0] & dp_h[1]);
    assign dn_s = (dn_r & dn_h[0]) | (dn_r & dn_h[1]) | (dn_h[0] & dn_h[1]);
`else
    assign dp_s = dp_r;
    assign dn_s = dn_r;
`endif

    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            dp_p <= 1'b0;
        end else begin
            dp_p <= dp_s;
        end
    end

    assign edge_det  = dp_s ^ dp_p;
    assign sample_pt = (state_q != StHunt) && (phase_q == SP);

    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StHunt;
            phase_q    <= '0;
            edge_cnt_q <= '0;
            idle_cnt_q <= '0;
            bitStrobe  <= 1'b0;
            bitValue   <= 1'b0;
            se0        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            bitStrobe <= sample_pt;
            if (sample_pt) begin
                bitValue <= dp_s;
                se0      <= ~dp_s & ~dn_s;
            end

            unique case (state_q)
                StHunt: begin
                    if (edge_det) begin
                        state_q    <= StLocking;
                        phase_q    <= PW'(1);
                        edge_cnt_q <= EW'(1);
                        idle_cnt_q <= '0;
                    end
                end
                StLocking, StLocked: begin
                    if (edge_det) begin
                        idle_cnt_q <= '0;
                        if (phase_q == SP) begin
                            // Edge at the sample point: resync phase and restart lock.
                            state_q    <= StLocking;
                            phase_q    <= PW'(1);
                            edge_cnt_q <= EW'(1);
                            locked     <= 1'b0;
                        end else begin
                            if (phase_q == '0) begin
                                phase_q <= phase_q + 1'b1;
                            end else if (phase_q < SP) begin
                                phase_q <= phase_q;
                            end else begin
                                phase_q <= phase_q + PW'(2);
                            end
                            if (state_q == StLocking) begin
                                edge_cnt_q <= edge_cnt_q + 1'b1;
                                if (edge_cnt_q >= EC_LCK) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                        if (bitStrobe) begin
                            if (idle_cnt_q == IC_TO) begin
                                state_q    <= StHunt;
                                phase_q    <= '0;
                                edge_cnt_q <= '0;
                                idle_cnt_q <= '0;
                                locked     <= 1'b0;
                            end else begin
                                idle_cnt_q <= idle_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StHunt;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
